// File: rtl/flop_pipe_pkg.sv
// rtl/flop_pipe_pkg.sv - shared helpers for the elastic pipeline register
package flop_pipe_pkg;

   // Occupancy counter width: enough bits to represent 0..stages inclusive.
   function automatic int occ_width(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// rtl/flop_pipe_stage.sv - one valid/payload register pair of the elastic pipeline
module flop_pipe_stage
   import flop_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             en,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   // Payload only moves with a valid entry so bubbles never toggle the data flops.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (en) begin
         valid_d = d_valid;
         if (d_valid) begin
            data_d = d_data;
         end
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign q_valid = valid_q;
   assign q_data  = data_q;

endmodule

// File: rtl/flop_pipe.sv
// rtl/flop_pipe.sv - elastic valid/ready pipeline register with bubble collapse, flush and occupancy
module flop_pipe
   import flop_pipe_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int STAGES = 2,
   localparam int CW     = occ_width(STAGES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   logic [STAGES-1:0] en;
   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  q [STAGES];
   logic              accept;
   logic              emit;
   logic [CW-1:0]     count_d, count_q;

   // A stage may advance when it or any stage after it is empty, or the sink takes the head.
   always_comb begin : en_chain
      logic chain;
      en    = '0;
      chain = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         chain = chain | ~v[i];
         en[i] = chain;
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic             d_valid;
      logic [WIDTH-1:0] d_data;

      if (i == 0) begin : g_head
         assign d_valid = in_valid;
         assign d_data  = in_data;
      end else begin : g_body
         assign d_valid = v[i-1];
         assign d_data  = q[i-1];
      end

      flop_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .en      (en[i]),
         .d_valid (d_valid),
         .d_data  (d_data),
         .q_valid (v[i]),
         .q_data  (q[i])
      );
   end

   assign in_ready  = en[0];
   assign out_valid = v[STAGES-1];
   assign out_data  = q[STAGES-1];
   assign accept    = in_valid & en[0];
   assign emit      = v[STAGES-1] & out_ready;

   always_comb begin
      count_d = count_q + CW'(accept) - CW'(emit);
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_flop_pipe.sv
// tb/tb_flop_pipe.sv - self-checking bench for flop_pipe (STAGES=3 streaming, STAGES=4 directed and random)
module tb_flop_pipe;

   localparam int S4 = 4;

   logic       clk = 1'b0;
   logic       reset;

   logic       flush3, in_valid3, in_ready3, out_valid3, out_ready3;
   logic [7:0] in_data3, out_data3;
   logic [1:0] count3;

   logic       flush4, in_valid4, in_ready4, out_valid4, out_ready4;
   logic [7:0] in_data4, out_data4;
   logic [2:0] count4;

   int checks = 0;
   int errors = 0;

   // Reference: each held entry is a payload plus the stage index it sits in.
   int         m_pos[$];
   logic [7:0] m_dat[$];

   always #5 clk = ~clk;

   flop_pipe #(.WIDTH(8), .STAGES(3)) u_dut3 (
      .clk(clk), .reset(reset), .flush(flush3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .count(count3)
   );

   flop_pipe #(.WIDTH(8), .STAGES(S4)) u_dut4 (
      .clk(clk), .reset(reset), .flush(flush4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .count(count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ir(input logic ordy);
      return (m_pos.size() < S4) || ordy;
   endfunction

   function automatic void model_update(input logic rst, input logic iv, input logic [7:0] id,
                                        input logic ordy, input logic fl);
      int   n;
      logic acc, em;
      n   = m_pos.size();
      acc = iv && ((n < S4) || ordy);
      em  = (n > 0) && (m_pos[0] == S4 - 1) && ordy;
      // An entry moves if the sink is taking data or there is a free slot somewhere ahead of it.
      for (int k = 0; k < n; k++) begin
         if ((ordy || (k + 1 < S4 - m_pos[k])) && (m_pos[k] < S4 - 1)) begin
            m_pos[k] = m_pos[k] + 1;
         end
      end
      if (em) begin
         void'(m_pos.pop_front());
         void'(m_dat.pop_front());
      end
      if (rst || fl) begin
         m_pos.delete();
         m_dat.delete();
      end else if (acc) begin
         m_pos.push_back(0);
         m_dat.push_back(id);
      end
   endfunction

   task automatic step4(input logic rst, input logic iv, input logic [7:0] id,
                        input logic ordy, input logic fl);
      reset      = rst;
      in_valid4  = iv;
      in_data4   = id;
      out_ready4 = ordy;
      flush4     = fl;
      #1;
      chk("in_ready", in_ready4, model_ir(ordy));
      @(posedge clk);
      model_update(rst, iv, id, ordy, fl);
      @(negedge clk);
      chk("out_valid", out_valid4, (m_pos.size() > 0) && (m_pos[0] == S4 - 1));
      chk("count", count4, m_pos.size());
      if ((m_pos.size() > 0) && (m_pos[0] == S4 - 1)) begin
         chk("out_data", out_data4, m_dat[0]);
      end
   endtask

   initial begin
      int acc_n, em_n;
      logic exp_v;
      logic [7:0] head;

      reset = 1'b1;
      flush3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
      flush4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
      @(negedge clk);

      step4(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step4(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step4(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_out_valid4", out_valid4, 0);
      chk("rst_out_data4", out_data4, 0);
      chk("rst_count4", count4, 0);
      chk("rst_in_ready4", in_ready4, 1);
      chk("rst_out_valid3", out_valid3, 0);
      chk("rst_out_data3", out_data3, 0);
      chk("rst_count3", count3, 0);
      chk("rst_in_ready3", in_ready3, 1);

      for (int k = 0; k < 14; k++) begin
         in_valid3  = (k < 10);
         in_data3   = 8'(k + 1);
         out_ready3 = 1'b1;
         #1;
         chk("s3_in_ready", in_ready3, 1);
         @(posedge clk);
         @(negedge clk);
         acc_n = (k + 1 < 10) ? k + 1 : 10;
         em_n  = (k - 2 < 0) ? 0 : ((k - 2 > 10) ? 10 : k - 2);
         exp_v = (k >= 2) && (k <= 11);
         chk("s3_count", count3, acc_n - em_n);
         chk("s3_out_valid", out_valid3, exp_v);
         if (exp_v) chk("s3_out_data", out_data3, k - 1);
      end
      in_valid3  = 1'b0;
      out_ready3 = 1'b0;

      step4(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
      step4(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step4(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step4(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("bp_count", count4, 2);
      chk("bp_head", out_data4, 8'hA1);
      step4(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("bp_second_valid", out_valid4, 1);
      chk("bp_second_data", out_data4, 8'hA2);
      step4(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("bp_drained", out_valid4, 0);

      for (int k = 0; k < 4; k++) step4(1'b0, 1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0);
      chk("full_count", count4, 4);
      #1;
      chk("full_in_ready", in_ready4, 0);
      for (int k = 0; k < 6; k++) begin
         step4(1'b0, 1'b1, 8'hC0 + 8'(k), 1'b1, 1'b0);
         chk("sim_count", count4, 4);
      end

      step4(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_flush_count", count4, 3);
      head = m_dat[0];
      chk("pre_flush_head", out_data4, head);
      step4(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
      chk("flush_count", count4, 0);
      chk("flush_out_valid", out_valid4, 0);
      #1;
      chk("flush_in_ready", in_ready4, 1);
      for (int k = 0; k < 5; k++) begin
         step4(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("flush_no_55", out_valid4, 0);
      end

      step4(1'b0, 1'b1, 8'hD1, 1'b0, 1'b0);
      step4(1'b0, 1'b1, 8'hD2, 1'b0, 1'b0);
      step4(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre_rst_count", count4, 2);
      step4(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_count", count4, 0);
      chk("mid_rst_out_valid", out_valid4, 0);
      chk("mid_rst_out_data", out_data4, 0);
      chk("mid_rst_in_ready", in_ready4, 1);
      for (int k = 0; k < 5; k++) begin
         step4(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("mid_rst_no_stale", out_valid4, 0);
      end

      for (int k = 0; k < 500; k++) begin
         step4($urandom_range(0, 127) == 0,
               $urandom_range(0, 9) < 7,
               8'($urandom),
               $urandom_range(0, 9) < 6,
               $urandom_range(0, 31) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
